// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: word-addressed program counter and fetch sequencer.
// Holds the PC that addresses IMem and computes the next PC each cycle from
// stall, halt, jump, branch and sequential requests. It also runs a
// BOOT/RUN/HALT state machine and a saturating retired-instruction counter.
// Optional feature macro: PC_RANGE_CHECK_EN. When defined, a next PC outside
// IMem (>= IMEM_DEPTH) halts the core with Fault set. When undefined, Fault
// is 0 and the PC wraps silently.
module pc_fetch_unit #(
    parameter int              PC_W       = 32,
    parameter logic [PC_W-1:0] RESET_PC   = '0,
    parameter int              IMEM_DEPTH = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            Stall,
    input  logic            Branch,
    input  logic [PC_W-1:0] BranchOff,
    input  logic            Jump,
    input  logic [PC_W-1:0] JumpTarget,
    input  logic            Halt,
    output logic [PC_W-1:0] PCOut,
    output logic [PC_W-1:0] PCPlus1,
    output logic            Running,
    output logic            Halted,
    output logic [31:0]     InsCount,
    output logic            Fault
);

`ifdef PC_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    // IMem depth widened by one bit so the comparison never truncates.
    localparam logic [PC_W:0] DEPTH_EXT = (PC_W + 1)'(IMEM_DEPTH);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic [31:0]     r_insCount;
    logic            r_running;
    logic            r_halted;
    logic            r_fault;

    logic [PC_W-1:0] w_nextPc;
    logic            w_outOfRange;
    logic [31:0]     w_countNext;

    // Select the redirect target: Jump beats Branch, otherwise step by one.
    always_comb begin
        w_nextPc = r_pc + PC_W'(1);
        if (Jump) begin
            w_nextPc = JumpTarget;
        end else if (Branch) begin
            w_nextPc = r_pc + BranchOff;
        end
    end

    // Flag a next PC that would fall outside IMem; only acted on when enabled.
    always_comb begin
        w_outOfRange = RANGE_CHECK && ({1'b0, w_nextPc} >= DEPTH_EXT);
    end

    // Retired-instruction count with saturation at all ones.
    always_comb begin
        w_countNext = r_insCount;
        if (r_insCount != 32'hFFFF_FFFF) begin
            w_countNext = r_insCount + 32'd1;
        end
    end

    // Boot/run/halt sequencer owning PC, counter and all status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_BOOT;
            r_pc       <= RESET_PC;
            r_insCount <= 32'd0;
            r_running  <= 1'b0;
            r_halted   <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    r_state   <= ST_RUN;
                    r_running <= 1'b1;
                end
                ST_RUN: begin
                    if (!Stall) begin
                        r_insCount <= w_countNext;
                        if (Halt) begin
                            r_state   <= ST_HALT;
                            r_running <= 1'b0;
                            r_halted  <= 1'b1;
                        end else if (w_outOfRange) begin
                            r_state   <= ST_HALT;
                            r_running <= 1'b0;
                            r_halted  <= 1'b1;
                            r_fault   <= 1'b1;
                        end else begin
                            r_pc <= w_nextPc;
                        end
                    end
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_BOOT;
                end
            endcase
        end
    end

    assign PCOut    = r_pc;
    assign PCPlus1  = r_pc + PC_W'(1);
    assign Running  = r_running;
    assign Halted   = r_halted;
    assign InsCount = r_insCount;
    assign Fault    = RANGE_CHECK & r_fault;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: table-driven bench for pc_fetch_unit with hand-written
// sequences for halt freeze, asynchronous mid-run reset and PC wrap/range.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        Stall;
    logic        Branch;
    logic [31:0] BranchOff;
    logic        Jump;
    logic [31:0] JumpTarget;
    logic        Halt;
    logic [31:0] PCOut;
    logic [31:0] PCPlus1;
    logic        Running;
    logic        Halted;
    logic [31:0] InsCount;
    logic        Fault;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        stall;
        logic        branch;
        logic [31:0] off;
        logic        jump;
        logic [31:0] target;
        logic        halt;
        logic [31:0] expPc;
        logic [31:0] expCnt;
        logic        expRun;
        logic        expHalt;
    } vec_t;

    vec_t vecs[14];

    pc_fetch_unit #(
        .PC_W(32),
        .RESET_PC(32'd0),
        .IMEM_DEPTH(32)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .Stall(Stall),
        .Branch(Branch),
        .BranchOff(BranchOff),
        .Jump(Jump),
        .JumpTarget(JumpTarget),
        .Halt(Halt),
        .PCOut(PCOut),
        .PCPlus1(PCPlus1),
        .Running(Running),
        .Halted(Halted),
        .InsCount(InsCount),
        .Fault(Fault)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] expPc,
                               input logic [31:0] expCnt, input logic expRun,
                               input logic expHalt, input logic expFault);
        compare({name, ".PCOut"}, PCOut, expPc);
        compare({name, ".PCPlus1"}, PCPlus1, expPc + 32'd1);
        compare({name, ".InsCount"}, InsCount, expCnt);
        compare({name, ".Running"}, {31'd0, Running}, {31'd0, expRun});
        compare({name, ".Halted"}, {31'd0, Halted}, {31'd0, expHalt});
        compare({name, ".Fault"}, {31'd0, Fault}, {31'd0, expFault});
    endtask

    // Drive one cycle of requests, clock one edge, settle 1ns past the edge.
    task automatic applyStimulus(input logic st, input logic br, input logic [31:0] off,
                                 input logic jp, input logic [31:0] tgt, input logic hl);
        Stall      = st;
        Branch     = br;
        BranchOff  = off;
        Jump       = jp;
        JumpTarget = tgt;
        Halt       = hl;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulusIdle();

        // Vectors: inputs for one edge, then expected state after that edge.
        vecs[0]  = '{1'b0, 1'b0, 32'd0,          1'b0, 32'd0, 1'b0, 32'd0, 32'd0,  1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 32'd0,          1'b0, 32'd0, 1'b0, 32'd1, 32'd1,  1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 32'd0,          1'b0, 32'd0, 1'b0, 32'd2, 32'd2,  1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 32'd0,          1'b0, 32'd0, 1'b0, 32'd3, 32'd3,  1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 32'd0,          1'b1, 32'd7, 1'b0, 32'd7, 32'd4,  1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 32'hFFFF_FFFE,  1'b0, 32'd0, 1'b0, 32'd5, 32'd5,  1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 32'd5,          1'b1, 32'd2, 1'b0, 32'd2, 32'd6,  1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 32'd2,          1'b0, 32'd0, 1'b0, 32'd4, 32'd7,  1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 32'd9,          1'b0, 32'd0, 1'b0, 32'd4, 32'd7,  1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 32'd9,          1'b1, 32'd20, 1'b1, 32'd4, 32'd7, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 32'd3,          1'b0, 32'd0, 1'b0, 32'd4, 32'd7,  1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 32'd3,          1'b0, 32'd0, 1'b0, 32'd7, 32'd8,  1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 32'd2,          1'b0, 32'd0, 1'b0, 32'd9, 32'd9,  1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 32'd0,          1'b0, 32'd0, 1'b1, 32'd9, 32'd10, 1'b0, 1'b1};

        // Reset state while rst_n is held low.
        #12;
        checkOutput("reset", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);

        // Release between edges; the unit sits in BOOT until the next edge.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("boot", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].stall, vecs[i].branch, vecs[i].off,
                          vecs[i].jump, vecs[i].target, vecs[i].halt);
            checkOutput($sformatf("vec%0d", i), vecs[i].expPc, vecs[i].expCnt,
                        vecs[i].expRun, vecs[i].expHalt, 1'b0);
        end

        // HALT is frozen against any request pattern.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                          1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
        end
        checkOutput("haltFrozen", 32'd9, 32'd10, 1'b0, 1'b1, 1'b0);

        // Bring the unit back and steer it to PC=6.
        doReset();
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'd6, 1'b0);
        checkOutput("preReset", 32'd6, 32'd1, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset between edges takes effect without a clock.
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncReset", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        checkOutput("postResetBoot", 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        checkOutput("postResetRun", 32'd1, 32'd1, 1'b1, 1'b0, 1'b0);

`ifdef PC_RANGE_CHECK_EN
        // Last IMem word steps out of range: hold PC, count it, fault and halt.
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'd31, 1'b0);
        checkOutput("toLastWord", 32'd31, 32'd2, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        checkOutput("rangeFault", 32'd31, 32'd3, 1'b0, 1'b1, 1'b1);
`else
        // Top of the address space wraps silently to zero.
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        checkOutput("toTop", 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        checkOutput("wrap", 32'd0, 32'd3, 1'b1, 1'b0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    task automatic applyStimulusIdle();
        Stall      = 1'b0;
        Branch     = 1'b0;
        BranchOff  = 32'd0;
        Jump       = 1'b0;
        JumpTarget = 32'd0;
        Halt       = 1'b0;
    endtask

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Program-counter and fetch-sequencing stage that sits directly upstream of the instruction memory in the single-cycle core. It holds the word-addressed PC that drives the IMem address input and computes the next PC each cycle from sequential, branch, jump, stall and halt requests supplied by the controller. It also runs a small boot/run/halt state machine and a retired-instruction counter for bench and debug visibility.

Parameters:
PC_W, 32, width of PC and all address/offset ports
RESET_PC, 0, word address loaded into PC on reset
IMEM_DEPTH, 32, number of instruction words in IMem (used only by the optional range check)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
Stall  in  1  hold PC and counters this cycle
Branch  in  1  conditional branch taken (already resolved by controller/ALU)
BranchOff  in  PC_W  signed word offset, relative to current PCOut
Jump  in  1  unconditional jump
JumpTarget  in  PC_W  absolute word address for a jump
Halt  in  1  current instruction is the halt instruction (0x00000012)
PCOut  out  PC_W  current word address, to IMem AddrIn
PCPlus1  out  PC_W  PCOut+1, combinational, to link/writeback path
Running  out  1  state is RUN
Halted  out  1  state is HALT
InsCount  out  32  retired-instruction count
Fault  out  1  PC left IMem range (optional feature only, else 0)

Behaviour:
- Reset (rst_n=0, asynchronous): state=BOOT, PCOut=RESET_PC, InsCount=0, Running=0, Halted=0, Fault=0. The reset is honoured in any state, including mid-run and in HALT.
- BOOT: lasts exactly one clock after reset release. PC is held and InsCount is not incremented. Next state is RUN. All request inputs are ignored.
- RUN: each rising edge without Stall retires the instruction at PCOut. InsCount increments by 1 and saturates at 0xFFFFFFFF.
- Next-PC priority in RUN, highest first:
  - Stall=1: PC and InsCount hold. Branch, Jump and Halt are ignored that cycle; the controller holds them until Stall drops.
  - Halt=1: PC holds at the halt instruction's address, the halt instruction is counted, next state is HALT.
  - Jump=1: PC<=JumpTarget.
  - Branch=1: PC<=PCOut+BranchOff, modulo 2^PC_W; a negative offset is two's complement.
  - Otherwise: PC<=PCOut+1.
- Simultaneous Jump and Branch: Jump wins.
- HALT: PC, InsCount and state are frozen. Only reset leaves HALT. Halted=1 and Running=0.
- PCPlus1 is always PCOut+1 modulo 2^PC_W, combinational.
- Latency: a redirect requested in cycle n appears on PCOut after edge n. There is no bubble and no delay slot.
- Without the optional feature, PC wraps from 2^PC_W-1 to 0 silently.

Optional Feature:
Macro PC_RANGE_CHECK_EN.
- Defined: in RUN, if the computed next PC is >= IMEM_DEPTH, PC holds, the current instruction is counted, Fault<=1 and the state goes to HALT. Fault stays 1 until reset.
- Undefined: no check is made, Fault is tied to 0, and PC wraps as above.

Test Plan:
- Reset release with RESET_PC=0, no requests, 5 edges -> PCOut sequence 0,0,1,2,3, Running=1 from the second edge, InsCount=3.
- In RUN at PC=7, Branch=1, BranchOff=0xFFFFFFFE -> next PCOut=5. Jump=1, JumpTarget=2 and Branch=1 at the same time -> next PCOut=2.
- Stall=1 for 3 cycles at PC=4 with Branch=1 asserted -> PCOut stays 4 and InsCount is unchanged. After Stall drops, with BranchOff=3 -> PCOut=7.
- Halt=1 at PC=9 -> PCOut stays 9, Halted=1, InsCount frozen at its value plus 1. Then 10 further edges with random Jump/Branch -> no change.
- rst_n pulsed low mid-RUN at PC=6 (asynchronous, between edges) -> PCOut=0 and InsCount=0 immediately, followed by a BOOT cycle.
- PC_RANGE_CHECK_EN defined, IMEM_DEPTH=32, PC=31, no requests -> Fault=1, Halted=1, PCOut=31. With the macro undefined, Jump to 0xFFFFFFFF then a sequential step -> PCOut=0 and Fault=0.
